// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler
//   Sequencer wrapped around a 4:1 single-bit mux. It steps the mux select
//   through channels 0..3 and holds each channel for SETTLE cycles. On the
//   last cycle of each hold it samples the mux output into a shadow register.
//   After channel 3 it publishes the assembled 4-bit word together with a
//   one-cycle valid pulse.
//
//   Optional feature: define MUX_SCAN_CONT_EN for continuous scanning. In that
//   mode one start keeps the sequencer scanning until reset. Without it, each
//   scan is one-shot and needs a new start.
//
//   Ports:
//     clk_i    rising-edge clock
//     rst_i    synchronous, active-high reset
//     start_i  scan request, honoured only while idle
//     y_i      mux output being scanned
//     sel_o    mux select (2 bits)
//     busy_o   high while a scan is in progress
//     word_o   last completed scan, bit k = y_i sampled with sel_o = k
//     valid_o  one-cycle pulse when word_o updates
//
//   Parameter SETTLE (1..15): cycles each channel is held before sampling.
module mux_scan_sampler #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       y_i,
  output logic [1:0] sel_o,
  output logic       busy_o,
  output logic [3:0] word_o,
  output logic       valid_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

`ifdef MUX_SCAN_CONT_EN
  localparam logic CONT_MODE = 1'b1;
`else
  localparam logic CONT_MODE = 1'b0;
`endif

  state_e     state_q,  state_d;
  logic [3:0] cnt_q,    cnt_d;
  logic [3:0] shadow_q, shadow_d;
  logic [1:0] sel_q,    sel_d;
  logic       busy_q,   busy_d;
  logic [3:0] word_q,   word_d;
  logic       valid_q,  valid_d;

  // The settle window of the current channel ends on this edge.
  logic sample_s;
  // The channel being sampled is the last one of the scan.
  logic last_ch_s;

  assign sample_s  = (state_q == SCAN) && (cnt_q == LAST_CNT);
  assign last_ch_s = (sel_q == 2'd3);

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      shadow_q <= 4'd0;
      sel_q    <= 2'd0;
      busy_q   <= 1'b0;
      word_q   <= 4'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (sample_s && last_ch_s && !CONT_MODE) begin
          state_d = IDLE;
        end else begin
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values. valid is a pulse, so it defaults low.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    word_d   = word_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d    = 4'd0;
          sel_d    = 2'd0;
          shadow_d = 4'd0;
          busy_d   = 1'b1;
        end else begin
          busy_d   = 1'b0;
        end
      end
      SCAN: begin
        if (sample_s) begin
          cnt_d           = 4'd0;
          shadow_d[sel_q] = y_i;
          if (last_ch_s) begin
            // The word includes the channel-3 sample taken on this same edge.
            word_d  = {y_i, shadow_q[2:0]};
            valid_d = 1'b1;
            sel_d   = 2'd0;
            busy_d  = CONT_MODE;
          end else begin
            sel_d   = sel_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        cnt_d  = 4'd0;
        sel_d  = 2'd0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign sel_o   = sel_q;
  assign busy_o  = busy_q;
  assign word_o  = word_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
module tb_mux_scan_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] d [2];
  logic       y_a, y_b;
  logic [1:0] sel_a, sel_b;
  logic       busy_a, busy_b, valid_a, valid_b;
  logic [3:0] word_a, word_b;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef MUX_SCAN_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural mux in front of each sampler.
  assign y_a = d[0][sel_a];
  assign y_b = d[1][sel_b];

  mux_scan_sampler #(.SETTLE(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .y_i(y_a),
    .sel_o(sel_a), .busy_o(busy_a), .word_o(word_a), .valid_o(valid_a)
  );

  mux_scan_sampler #(.SETTLE(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .y_i(y_b),
    .sel_o(sel_b), .busy_o(busy_b), .word_o(word_b), .valid_o(valid_b)
  );

  // Reference model: cycles elapsed since scan acceptance determine channel.
  typedef struct {
    logic       busy;
    logic       valid;
    logic [1:0] sel;
    logic [3:0] word;
    logic [3:0] sh;
    int         n;
  } mdl_t;

  mdl_t m [2];
  int   settle_of [2] = '{2, 1};

  task automatic model_step(input int i, input logic st, input logic r);
    int s;
    int k;
    s = settle_of[i];
    if (r) begin
      m[i].busy = 1'b0; m[i].valid = 1'b0; m[i].sel = 2'd0;
      m[i].word = 4'd0; m[i].sh = 4'd0;   m[i].n = 0;
    end else if (!m[i].busy) begin
      m[i].valid = 1'b0;
      if (st) begin
        m[i].busy = 1'b1; m[i].n = 0; m[i].sel = 2'd0;
      end
    end else begin
      m[i].valid = 1'b0;
      m[i].n = m[i].n + 1;
      if (m[i].n % s == 0) begin
        k = m[i].n / s - 1;
        m[i].sh[k] = d[i][k];
        if (k == 3) begin
          m[i].word  = m[i].sh;
          m[i].valid = 1'b1;
          m[i].sel   = 2'd0;
          m[i].n     = 0;
          m[i].busy  = CONT;
        end else begin
          m[i].sel = 2'(k + 1);
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // One clock: apply inputs, step the model at the edge, compare after it.
  task automatic tick(input logic st, input logic r);
    start = st;
    rst   = r;
    @(posedge clk);
    model_step(0, st, r);
    model_step(1, st, r);
    #1;
    chk("a.sel",   32'(sel_a),   32'(m[0].sel));
    chk("a.busy",  32'(busy_a),  32'(m[0].busy));
    chk("a.valid", 32'(valid_a), 32'(m[0].valid));
    chk("a.word",  32'(word_a),  32'(m[0].word));
    chk("b.sel",   32'(sel_b),   32'(m[1].sel));
    chk("b.busy",  32'(busy_b),  32'(m[1].busy));
    chk("b.valid", 32'(valid_b), 32'(m[1].valid));
    chk("b.word",  32'(word_b),  32'(m[1].word));
  endtask

  typedef struct {
    logic       st;
    logic       r;
    logic [1:0] e_sel;
    logic       e_busy;
    logic       e_valid;
    logic [3:0] e_word;
  } vec_t;

  vec_t vt [12];
  int   vcount;

  initial begin
    rst = 1'b1; start = 1'b1;
    d[0] = 4'b1010; d[1] = 4'b0110;
    for (int i = 0; i < 2; i++) begin
      m[i].busy = 1'b0; m[i].valid = 1'b0; m[i].sel = 2'd0;
      m[i].word = 4'd0; m[i].sh = 4'd0; m[i].n = 0;
    end

`ifndef MUX_SCAN_CONT_EN
    // Directed one-shot scan of dut_a (SETTLE=2, d=1010), start held in reset first.
    vt[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000};
    vt[1]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000};
    vt[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000};
    vt[3]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000};
    vt[4]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 4'b0000};
    vt[5]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 4'b0000};
    vt[6]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0000};
    vt[7]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0000};
    vt[8]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0000};
    vt[9]  = '{1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0000};
    vt[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1010};
    vt[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1010};
    for (int i = 0; i < 12; i++) begin
      tick(vt[i].st, vt[i].r);
      chk($sformatf("vec%0d.sel", i),   32'(sel_a),   32'(vt[i].e_sel));
      chk($sformatf("vec%0d.busy", i),  32'(busy_a),  32'(vt[i].e_busy));
      chk($sformatf("vec%0d.valid", i), 32'(valid_a), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d.word", i),  32'(word_a),  32'(vt[i].e_word));
    end
    // dut_b (SETTLE=1, d=0110) was accepted at vec2 and finished 4 edges later.
    chk("settle1.word", 32'(word_b), 32'(4'b0110));
`endif

    // New data, start on an idle cycle, start pulses during busy are ignored.
    tick(1'b0, 1'b1);
    d[0] = 4'b1101;
    tick(1'b1, 1'b0);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0);
      if (valid_a) vcount++;
    end
    chk("b2b.valid_count", 32'(vcount), 32'd1);
    chk("b2b.word", 32'(word_a), 32'(4'b1101));

    // Mid-scan reset while dut_a has sel=2: nothing partial may appear.
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    chk("midrst.sel_before", 32'(sel_a), 32'd2);
    tick(1'b0, 1'b1);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      if (valid_a) vcount++;
    end
    chk("midrst.word", 32'(word_a), 32'(4'b0000));
    chk("midrst.valid_count", 32'(vcount), 32'd0);
    chk("midrst.busy", 32'(busy_a), 32'd0);

`ifdef MUX_SCAN_CONT_EN
    // Continuous: one start, data changed between scans.
    tick(1'b0, 1'b1);
    d[0] = 4'b1010;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
    chk("cont.valid1", 32'(valid_a), 32'd1);
    chk("cont.word1", 32'(word_a), 32'(4'b1010));
    d[0] = 4'b1101;
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
    chk("cont.valid2", 32'(valid_a), 32'd1);
    chk("cont.word2", 32'(word_a), 32'(4'b1101));
    chk("cont.busy", 32'(busy_a), 32'd1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7, 0) == 0) d[0] = 4'($urandom);
      if ($urandom_range(7, 0) == 0) d[1] = 4'($urandom);
      tick(($urandom_range(3, 0) == 0), ($urandom_range(79, 0) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_sampler.md
# mux_scan_sampler

Sequencer that sits directly around the 4:1 dataflow mux. It drives the mux select lines through all four channels, waits a programmable settle time on each, samples the single-bit mux output, and reassembles the four samples into a 4-bit word. The word is presented with a one-cycle valid pulse. It lets downstream logic read a 4-input bank through the one-bit mux path under a start/busy handshake.

## Interface
- SETTLE, default 2: cycles `sel` is held stable per channel before `y` is sampled; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  scan request; sampled only while idle.
- y  input  1  mux output being scanned.
- sel  output  2  mux select; drives the mux `sel` port.
- busy  output  1  high while a scan is in progress.
- word  output  4  last completed scan; bit k = `y` sampled with `sel`=k.
- valid  output  1  one-cycle pulse when `word` updates.

## Operation
- Reset is synchronous on `clk`, active-high.
- Reset values: `sel`=2'b00, `busy`=0, `word`=4'b0000, `valid`=0, FSM=IDLE, settle counter=0, shadow register=0.
- FSM states:
  - IDLE: `busy`=0.
    - `start`=1 moves to SCAN.
    - At the same edge: `sel`←0, counter←0, `busy`←1.
  - SCAN: the counter increments each cycle.
    - When counter = SETTLE-1, `y` is written into shadow bit [`sel`] and the counter clears.
    - If `sel`<3: `sel`←`sel`+1.
    - If `sel`=3: `word`←full shadow (current `y` included), `valid`←1 for one cycle, `sel`←0, then go to IDLE (or restart; see Configuration).
- `word` updates atomically only on scan completion. Partial scans are never visible.
- `start` while `busy`=1 is ignored and is not queued.
- `sel` wraps 3→0 only at scan end. It never skips or repeats a channel within a scan.
- `rst` mid-scan aborts immediately. All values return to their reset values, and any partial shadow is discarded.
- `start` and `rst` high together: reset wins.
- SETTLE outside 1..15 is a configuration error and behaviour is unspecified. Counter width is 4 bits.

## Timing
- Let E0 be the edge where `start` is accepted.
- `sel`=k is valid from edge E0+k·SETTLE through edge E0+(k+1)·SETTLE.
- Channel k is sampled at edge E0+(k+1)·SETTLE.
- At edge E0+4·SETTLE:
  - `word` and `valid` update.
  - `busy` falls (one-shot mode).
- Latency from start acceptance to valid is 4·SETTLE cycles. For SETTLE=2, `valid` is high during the cycle after E0+8.
- A new `start` is accepted at the earliest at edge E0+4·SETTLE+1, the first edge with `busy`=0.
- `y` must be stable at least one full cycle before each sample edge. The upstream mux is combinational, so SETTLE=1 is sufficient in-design.

## Configuration
- MUX_SCAN_CONT_EN defined:
  - After the last sample the FSM stays in SCAN with `sel`←0 and `busy` held at 1.
  - `valid` pulses every 4·SETTLE cycles.
  - `start` is only needed once to leave IDLE; only `rst` stops scanning.
- MUX_SCAN_CONT_EN undefined: one-shot. The FSM returns to IDLE after each scan and needs a fresh `start`.

## Test plan
- Reset: hold `rst` 2 cycles with `start`=1 → `sel`=00, `busy`=0, `word`=0000, `valid`=0 throughout; no scan begins.
- One-shot, SETTLE=2, mux `d`=4'b1010, pulse `start`:
  - `sel` steps 00,01,10,11 for 2 cycles each.
  - `valid` pulses once 8 cycles after acceptance with `word`=1010.
  - `busy` falls at the same edge.
- Back-to-back runs:
  - Change `d` to 4'b1101 and pulse `start` on the first idle cycle → `word`=1101 and a single `valid`.
  - `start` pulses during `busy` → no extra scans or `valid` pulses.
- Mid-scan reset: assert `rst` while `sel`=10 → all outputs return to reset values, `word` stays 0000 (not a partial value), and no `valid` pulse occurs.
- SETTLE=1 with `d`=4'b0110 → `valid` 4 cycles after acceptance, `word`=0110.
- Continuous mode (MUX_SCAN_CONT_EN, SETTLE=2):
  - One `start`, with `d` changed from 1010 to 1101 between scans → `valid` every 8 cycles, `word` 1010 then 1101.
  - `busy` stays 1 until `rst`.
